// File: rtl/cnn_pkg.sv
`default_nettype none
//============================================================================
// Module   : cnn_pkg
// Purpose  : Shared CNN datapath defaults and signed-max helper.
// Revision : 1.0 - initial release
//============================================================================
package cnn_pkg;

    localparam int unsigned c_n_data = 32;
    localparam int unsigned c_max_w  = 64;

    // Operands arrive sign-extended to c_max_w so one helper serves any pixel width;
    // on a tie the first operand is returned, which equals the second anyway.
    function automatic logic signed [c_max_w-1:0] smax(
        input logic signed [c_max_w-1:0] a,
        input logic signed [c_max_w-1:0] b
    );
        return (a >= b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/c_shift_ram.sv
`default_nettype none
//============================================================================
// Module   : c_shift_ram
// Purpose  : Clock-enabled shift-register line buffer; o_data is the word
//            written N_LEN enabled cycles earlier.
// Revision : 1.0 - initial release
//============================================================================
module c_shift_ram #(
    parameter int N_DATA = 32,
    parameter int N_LEN  = 28
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ce,
    input  logic [N_DATA-1:0] i_data,
    output logic [N_DATA-1:0] o_data
);

    logic [N_DATA-1:0] r_sr [N_LEN];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N_LEN; i++) begin
                r_sr[i] <= '0;
            end
        end else if (i_ce) begin
            r_sr[0] <= i_data;
            for (int i = 1; i < N_LEN; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign o_data = r_sr[N_LEN-1];

endmodule
`default_nettype wire

// File: rtl/maxpool_2x2.sv
`default_nettype none
//============================================================================
// Module   : maxpool_2x2
// Purpose  : Streaming 2x2 stride-2 signed max-pool over a raster frame.
// Revision : 1.0 - initial release
//============================================================================
module maxpool_2x2
    import cnn_pkg::*;
#(
    parameter int N_DATA = c_n_data,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_clear,
    input  logic                     i_valid,
    input  logic signed [N_DATA-1:0] i_data,
    output logic                     o_valid,
    output logic signed [N_DATA-1:0] o_data,
    output logic                     o_last
);

    localparam int c_col_w = $clog2(IMG_W);
    localparam int c_row_w = $clog2(IMG_H);

    if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0 || IMG_W < 2 || IMG_H < 2) begin : g_bad_dims
        $error("maxpool_2x2: IMG_W and IMG_H must be even and >= 2");
    end

    logic                     w_beat;
    logic                     w_col_last;
    logic                     w_row_last;
    logic signed [N_DATA-1:0] w_top;
    logic signed [N_DATA-1:0] w_pair;
    logic signed [N_DATA-1:0] w_res;

    logic [c_col_w-1:0]       r_col;
    logic [c_row_w-1:0]       r_row;
    logic signed [N_DATA-1:0] r_m0;
    logic signed [N_DATA-1:0] r_data;
    logic                     r_valid;
    logic                     r_last;

    assign w_beat     = i_valid & ~i_clear;
    assign w_col_last = (r_col == c_col_w'(IMG_W - 1));
    assign w_row_last = (r_row == c_row_w'(IMG_H - 1));

    c_shift_ram #(
        .N_DATA (N_DATA),
        .N_LEN  (IMG_W)
    ) u_line_buf (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_ce    (w_beat),
        .i_data  (i_data),
        .o_data  (w_top)
    );

    // Column pair of the current window, then fold in the left-column partial.
    assign w_pair = N_DATA'(smax(c_max_w'(w_top), c_max_w'(i_data)));
    assign w_res  = N_DATA'(smax(c_max_w'(r_m0), c_max_w'(w_pair)));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_col   <= '0;
            r_row   <= '0;
            r_m0    <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (i_clear) begin
            r_col   <= '0;
            r_row   <= '0;
            r_m0    <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            if (w_beat) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
                // Odd rows close windows: even column stores the partial, odd column emits.
                if (r_row[0] && !r_col[0]) begin
                    r_m0 <= w_pair;
                end
                if (r_row[0] && r_col[0]) begin
                    r_data  <= w_res;
                    r_valid <= 1'b1;
                    r_last  <= w_row_last && w_col_last;
                end
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_maxpool_2x2.sv
`default_nettype none
//============================================================================
// Module   : tb_maxpool_2x2
// Purpose  : Self-checking bench for maxpool_2x2 (4x4 frames, 32-bit pixels).
// Revision : 1.0 - initial release
//============================================================================
module tb_maxpool_2x2;

    localparam int c_w = 4;
    localparam int c_h = 4;

    logic               clk;
    logic               rst_n;
    logic               clear;
    logic               valid;
    logic signed [31:0] data;
    logic               o_valid;
    logic signed [31:0] o_data;
    logic               o_last;

    int n_checks;
    int n_errors;

    // Reference model: raster position and the pixels of the current frame.
    int m_row;
    int m_col;
    int m_last;
    int m_frame [c_h][c_w];

    typedef struct {
        logic v;
        logic c;
        int   d;
        logic ev;
        int   ed;
        logic el;
    } vec_t;

    vec_t tbl [32];

    maxpool_2x2 #(
        .N_DATA (32),
        .IMG_W  (c_w),
        .IMG_H  (c_h)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clear (clear),
        .i_valid (valid),
        .i_data  (data),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_last  (o_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic int max2(input int a, input int b);
        return (a >= b) ? a : b;
    endfunction

    task automatic model_reset();
        m_row  = 0;
        m_col  = 0;
        m_last = 0;
    endtask

    task automatic model_step(input logic v, input logic c, input int d,
                              output logic ev, output int ed, output logic el);
        ev = 1'b0;
        el = 1'b0;
        if (c) begin
            m_row = 0;
            m_col = 0;
        end else if (v) begin
            m_frame[m_row][m_col] = d;
            if ((m_row % 2) == 1 && (m_col % 2) == 1) begin
                ev     = 1'b1;
                m_last = max2(max2(m_frame[m_row-1][m_col-1], m_frame[m_row-1][m_col]),
                              max2(m_frame[m_row][m_col-1], d));
                el     = (m_row == c_h - 1) && (m_col == c_w - 1);
            end
            m_col++;
            if (m_col == c_w) begin
                m_col = 0;
                m_row = (m_row == c_h - 1) ? 0 : m_row + 1;
            end
        end
        ed = m_last;
    endtask

    task automatic apply(input logic v, input logic c, input int d,
                         input logic ev, input int ed, input logic el, input string nm);
        @(negedge clk);
        valid = v;
        clear = c;
        data  = d;
        @(posedge clk);
        #1;
        chk({nm, ".valid"}, int'(o_valid), int'(ev));
        chk({nm, ".data"},  int'(o_data),  ed);
        chk({nm, ".last"},  int'(o_last),  int'(el));
    endtask

    task automatic mcycle(input logic v, input logic c, input int d, input string nm);
        logic ev;
        logic el;
        int   ed;
        model_step(v, c, d, ev, ed, el);
        apply(v, c, d, ev, ed, el, nm);
    endtask

    task automatic frame(input int base, input string nm);
        for (int k = 0; k < c_w * c_h; k++) begin
            mcycle(1'b1, 1'b0, base + k, nm);
        end
    endtask

    initial begin
        int   outb [4];
        int   negv [4];
        int   hold;
        logic ev;
        logic el;
        int   ed;

        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        clear    = 1'b0;
        valid    = 1'b0;
        data     = '0;
        model_reset();

        // Expected results straight from the frame arithmetic of the two reference frames.
        outb = '{5, 7, 13, 15};
        negv = '{-1, -3, -9, -11};
        hold = 0;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 16; k++) begin
                tbl[f*16+k].v  = 1'b1;
                tbl[f*16+k].c  = 1'b0;
                tbl[f*16+k].d  = (f == 0) ? k : -(k + 1);
                tbl[f*16+k].ev = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    if (k == outb[j]) begin
                        tbl[f*16+k].ev = 1'b1;
                        hold = (f == 0) ? outb[j] : negv[j];
                    end
                end
                tbl[f*16+k].ed = hold;
                tbl[f*16+k].el = tbl[f*16+k].ev && (k == 15);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("reset.valid", int'(o_valid), 0);
        chk("reset.data",  int'(o_data),  0);
        chk("reset.last",  int'(o_last),  0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) begin
            model_step(tbl[i].v, tbl[i].c, tbl[i].d, ev, ed, el);
            apply(tbl[i].v, tbl[i].c, tbl[i].d, tbl[i].ev, tbl[i].ed, tbl[i].el,
                  (i < 16) ? "table_pos" : "table_neg");
        end

        for (int k = 0; k < 16; k++) begin
            mcycle(1'b1, 1'b0, k, "gap_beat");
            mcycle(1'b0, 1'b0, 7777, "gap_idle");
        end

        frame(0, "b2b_a");
        frame(100, "b2b_b");

        for (int k = 0; k < 10; k++) begin
            mcycle(1'b1, 1'b0, 50 + k, "pre_clear");
        end
        mcycle(1'b1, 1'b1, 999, "clear_wins");
        mcycle(1'b0, 1'b0, 0, "post_clear_idle");
        frame(0, "after_clear");

        for (int k = 0; k < 7; k++) begin
            mcycle(1'b1, 1'b0, 200 + k, "pre_reset");
        end
        @(negedge clk);
        valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_async.valid", int'(o_valid), 0);
        chk("rst_async.data",  int'(o_data),  0);
        chk("rst_async.last",  int'(o_last),  0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_hold.valid", int'(o_valid), 0);
            chk("rst_hold.data",  int'(o_data),  0);
            chk("rst_hold.last",  int'(o_last),  0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        frame(0, "after_reset");

        for (int n = 0; n < 400; n++) begin
            logic rv;
            logic rc;
            int   rd;
            rv = ($urandom_range(0, 9) < 7);
            rc = ($urandom_range(0, 59) == 0);
            rd = ($urandom_range(0, 1) == 1) ? int'($urandom) : int'($urandom_range(0, 7)) - 4;
            mcycle(rv, rc, rd, "random");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/maxpool_2x2.md
MAXPOOL_2X2 -- requirements
Module: maxpool_2x2

Interface
REQ-001 SHALL have parameter N_DATA, default 32: pixel width, two's-complement signed.
REQ-002 SHALL have parameter IMG_W, default 28: pixels per row; must be even and >= 2.
REQ-003 SHALL have parameter IMG_H, default 28: rows per frame; must be even and >= 2.
REQ-004 SHALL have port i_clk, input, 1: clock; all logic on rising edge.
REQ-005 SHALL have port i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port i_clear, input, 1: synchronous frame flush.
REQ-007 SHALL have port i_valid, input, 1: input beat qualifier; row-major raster order.
REQ-008 SHALL have port i_data, input, N_DATA: input pixel.
REQ-009 SHALL have port o_valid, output, 1: one-cycle result strobe.
REQ-010 SHALL have port o_data, output, N_DATA: pooled pixel.
REQ-011 SHALL have port o_last, output, 1: marks the final pooled pixel of a frame.

Function
REQ-012 SHALL track column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1), advancing only on accepted beats (i_valid=1, i_clear=0).
REQ-013 SHALL wrap col to 0 after IMG_W-1 and increment row; SHALL wrap row to 0 after IMG_H-1 with col=IMG_W-1, so the next frame starts with no idle cycle.
REQ-014 SHALL provide a line buffer of depth IMG_W shifted only on accepted beats; its output during a beat is the pixel accepted IMG_W beats earlier, i.e. the same column in the previous row.
REQ-015 On an accepted beat with row odd and col even, SHALL register partial m0 = signed max(top, i_data), where top is the line-buffer output.
REQ-016 On an accepted beat with row odd and col odd, SHALL register o_data = signed max(m0, top, i_data) and assert o_valid for exactly one cycle, so latency is 1 cycle after the completing beat.
REQ-017 SHALL produce no output on even rows; per frame it SHALL emit exactly (IMG_W/2)*(IMG_H/2) results.
REQ-018 SHALL assert o_last with o_valid only for the result at row=IMG_H-1, col=IMG_W-1.
REQ-019 All comparisons SHALL be signed N_DATA-bit; ties SHALL select the equal value; there SHALL be no width growth.
REQ-020 Gaps in i_valid SHALL stall counters, line buffer and m0 without corrupting results.
REQ-021 Outside the result cycle, o_valid and o_last SHALL be 0; o_data SHALL hold its last value.
REQ-022 i_clear=1 SHALL zero col, row, m0, o_valid and o_last on the next edge; line-buffer contents become don't-care.
REQ-023 If i_clear and i_valid are both 1, clear SHALL win and the beat SHALL be dropped.
REQ-024 There SHALL be no backpressure; the downstream side must accept every o_valid.

Reset
REQ-025 While i_rst_n=0, col, row, m0, line buffer, o_data, o_valid and o_last SHALL be 0.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; the first beat after release SHALL be row 0, col 0.

Structure
REQ-027 The default N_DATA and a signed-max function SHALL live in shared package cnn_pkg.
REQ-028 The line buffer SHALL be one instance of the existing shift-RAM line buffer c_shift_ram, with N_DATA=N_DATA, N_LEN=IMG_W and i_ce driven by the accepted-beat signal.
REQ-029 An elaboration-time check SHALL reject odd IMG_W or odd IMG_H.

Verification (IMG_W=4, IMG_H=4, N_DATA=32)
REQ-030 Pixels 0..15 sent back-to-back -> o_valid pulses with o_data 5, 7, 13, 15, each 1 cycle after beats 5, 7, 13, 15 (zero-based); o_last only with 15.
REQ-031 Pixels -1..-16 (pixel k = -(k+1)) -> outputs -1, -3, -9, -11; this confirms signed comparison.
REQ-032 Same frame as REQ-030 with i_valid low every other cycle -> same four values, each 1 cycle after its completing beat.
REQ-033 Two frames back-to-back (0..15, then 100..115) -> 5, 7, 13, 15, 105, 107, 113, 115; o_last twice.
REQ-034 i_clear after beat 9 of a frame, then a full frame 0..15 -> no output from the aborted frame after the clear; then 5, 7, 13, 15.
REQ-035 i_rst_n pulsed low after beat 6, then frame 0..15 -> all outputs 0 during reset; then 5, 7, 13, 15.
